gac_rr_arbiter_6: RTL

- Registered round-robin arbiter that shares one resource among six requesters, e.g. the shared memory port or the register-file write port in the superscalar pipeline.
- Built around a six-way request OR-reduction ("any request") and a rotating priority pointer.
- Grants one owner at a time and holds the grant until the owner signals done, drops its request, or exceeds a hold limit while others wait.
- Sits between the issue/execute units (requesters) and the shared datapath resource mux, which is steered by gnt_id.

---
 rtl/gac_rr_arbiter_6.sv | 92 +++++++++
 1 files changed

// File: rtl/gac_rr_arbiter_6.sv
// gac_rr_arbiter_6: registered round-robin arbiter sharing one resource among N_REQ requesters
module gac_rr_arbiter_6 #(
    parameter int N_REQ    = 6,
    parameter int MAX_HOLD = 8,
    parameter int ID_W     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [ID_W-1:0]  gnt_id,
    output logic             any_req
);
    localparam int HC_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HC_W-1:0] HOLD_LIM = HC_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t           r_state;
    logic [N_REQ-1:0] r_gnt;
    logic [ID_W-1:0]  r_gnt_id;
    logic [ID_W-1:0]  r_ptr;
    logic [HC_W-1:0]  r_hold;

    logic [ID_W-1:0]  w_start;
    logic [ID_W-1:0]  w_next;
    logic             w_found;
    logic             w_release;

    // circular index: base + offset, wrapped into 0..N_REQ-1
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        int k;
        k = int'(base) + off;
        return ID_W'((k >= N_REQ) ? k - N_REQ : k);
    endfunction

    assign any_req   = |req;
    assign gnt       = r_gnt;
    assign gnt_valid = |r_gnt;
    assign gnt_id    = r_gnt_id;

    // search starts just past the owner while granting, so the owner is considered last
    assign w_start = (r_state == S_GRANT) ? wrap_add(r_gnt_id, 1) : r_ptr;

    // release on done, owner dropping its request, or hold limit reached with others waiting
    assign w_release = done || !(|(req & r_gnt)) ||
                       ((MAX_HOLD > 0) && (r_hold == HOLD_LIM) && (|(req & ~r_gnt)));

    // first pending requester in circular order from w_start; scanning backwards lets the nearest win
    always_comb begin
        w_found = 1'b0;
        w_next  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[wrap_add(w_start, i)]) begin
                w_found = 1'b1;
                w_next  = wrap_add(w_start, i);
            end
        end
    end

    // grant FSM: idle load, back-to-back handover on release, saturating hold counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_ptr    <= '0;
            r_hold   <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_found) begin
                r_state  <= S_GRANT;
                r_gnt    <= N_REQ'(1) << w_next;
                r_gnt_id <= w_next;
                r_hold   <= '0;
            end
        end else if (w_release) begin
            r_ptr  <= w_start;
            r_hold <= '0;
            if (w_found) begin
                r_gnt    <= N_REQ'(1) << w_next;
                r_gnt_id <= w_next;
            end else begin
                r_state <= S_IDLE;
                r_gnt   <= '0;
            end
        end else begin
            r_hold <= (r_hold == HOLD_LIM) ? r_hold : r_hold + HC_W'(1);
        end
    end
endmodule
